// File: rtl/login_session_controller.sv
// Login sequencer: collects a 4-digit code and user slot, strobes the password manager,
// waits a bounded time for a match, and tracks login, failed attempts and timed lockout.
module login_session_controller #(
   parameter int TIMEOUT     = 8,
   parameter int MAX_FAIL    = 3,
   parameter int LOCK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic [2:0] user_sel,
   input  logic       logout,
   input  logic       pass_checked,
   output logic       pwd_out,
   output logic [2:0] pass_adrs,
   output logic [3:0] pwd1,
   output logic [3:0] pwd2,
   output logic [3:0] pwd3,
   output logic [3:0] pwd4,
   output logic       pm_rst_n,
   output logic       logged_in,
   output logic       locked,
   output logic [1:0] fail_cnt,
   output logic [2:0] digit_cnt
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int LW = $clog2(LOCK_CYCLES + 1);
   localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
   localparam logic [1:0]    FAIL_MAX  = 2'(MAX_FAIL);
   localparam logic [3:0]    KEY_CLEAR = 4'hF;

   typedef enum logic [2:0] {
      IDLE,
      ENTRY,
      REQ,
      WAIT,
      GRANTED,
      FAIL,
      LOCKED
   } state_t;

   state_t        state;
   logic [TW-1:0] wait_timer;
   logic [LW-1:0] lock_timer;
   logic          key_digit;

   assign key_digit = key_valid && (key_code <= 4'd9);

   // Outputs are registered, so each strobe is set on the edge that enters its state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         wait_timer <= '0;
         lock_timer <= '0;
         pwd_out    <= 1'b0;
         pass_adrs  <= '0;
         pwd1       <= '0;
         pwd2       <= '0;
         pwd3       <= '0;
         pwd4       <= '0;
         pm_rst_n   <= 1'b0;
         logged_in  <= 1'b0;
         locked     <= 1'b0;
         fail_cnt   <= '0;
         digit_cnt  <= '0;
      end else begin
         pwd_out  <= 1'b0;
         pm_rst_n <= 1'b1;
         case (state)
            IDLE: begin
               if (key_digit) begin
                  pwd1      <= key_code;
                  pass_adrs <= user_sel;
                  digit_cnt <= 3'd1;
                  state     <= ENTRY;
               end
            end
            ENTRY: begin
               if (key_valid && key_code == KEY_CLEAR) begin
                  pwd1      <= '0;
                  pwd2      <= '0;
                  pwd3      <= '0;
                  pwd4      <= '0;
                  digit_cnt <= '0;
                  state     <= IDLE;
               end else if (key_digit) begin
                  digit_cnt <= digit_cnt + 3'd1;
                  case (digit_cnt)
                     3'd1:    pwd2 <= key_code;
                     3'd2:    pwd3 <= key_code;
                     default: begin
                        pwd4    <= key_code;
                        pwd_out <= 1'b1;
                        state   <= REQ;
                     end
                  endcase
               end
            end
            REQ: begin
               wait_timer <= '0;
               state      <= WAIT;
            end
            WAIT: begin
               if (pass_checked) begin
                  fail_cnt  <= '0;
                  logged_in <= 1'b1;
                  state     <= GRANTED;
               end else if (wait_timer == WAIT_LAST) begin
                  pm_rst_n  <= 1'b0;
                  pwd1      <= '0;
                  pwd2      <= '0;
                  pwd3      <= '0;
                  pwd4      <= '0;
                  digit_cnt <= '0;
                  if (fail_cnt != FAIL_MAX)
                     fail_cnt <= fail_cnt + 2'd1;
                  state <= FAIL;
               end else begin
                  wait_timer <= wait_timer + 1'b1;
               end
            end
            GRANTED: begin
               if (logout) begin
                  pm_rst_n  <= 1'b0;
                  pwd1      <= '0;
                  pwd2      <= '0;
                  pwd3      <= '0;
                  pwd4      <= '0;
                  digit_cnt <= '0;
                  logged_in <= 1'b0;
                  state     <= IDLE;
               end
            end
            FAIL: begin
               if (fail_cnt == FAIL_MAX) begin
                  lock_timer <= '0;
                  locked     <= 1'b1;
                  state      <= LOCKED;
               end else begin
                  state <= IDLE;
               end
            end
            LOCKED: begin
               if (lock_timer == LOCK_LAST) begin
                  locked   <= 1'b0;
                  fail_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  lock_timer <= lock_timer + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_login_session_controller.sv
// Directed bench for login_session_controller with TIMEOUT=8, MAX_FAIL=3, LOCK_CYCLES=16.
module tb_login_session_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = '0;
   logic [2:0] user_sel = '0;
   logic       logout = 1'b0;
   logic       pass_checked = 1'b0;
   logic       pwd_out;
   logic [2:0] pass_adrs;
   logic [3:0] pwd1, pwd2, pwd3, pwd4;
   logic       pm_rst_n, logged_in, locked;
   logic [1:0] fail_cnt;
   logic [2:0] digit_cnt;

   int n_checks = 0;
   int n_errors = 0;

   login_session_controller #(
      .TIMEOUT    (8),
      .MAX_FAIL   (3),
      .LOCK_CYCLES(16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .user_sel    (user_sel),
      .logout      (logout),
      .pass_checked(pass_checked),
      .pwd_out     (pwd_out),
      .pass_adrs   (pass_adrs),
      .pwd1        (pwd1),
      .pwd2        (pwd2),
      .pwd3        (pwd3),
      .pwd4        (pwd4),
      .pm_rst_n    (pm_rst_n),
      .logged_in   (logged_in),
      .locked      (locked),
      .fail_cnt    (fail_cnt),
      .digit_cnt   (digit_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] k);
      key_valid = 1'b1;
      key_code  = k;
      tick();
      key_valid = 1'b0;
   endtask

   task automatic enter4(input logic [3:0] a, b, c, d);
      press(a);
      press(b);
      press(c);
      press(d);
   endtask

   // Four digits, then REQ->WAIT, then the eight WAIT cycles that end in FAIL.
   task automatic timeout_attempt(input logic [1:0] exp_fail);
      enter4(4'd1, 4'd1, 4'd1, 4'd1);
      tick();
      for (int i = 0; i < 7; i++) tick();
      check("to_pmrst_before", {31'd0, pm_rst_n}, 32'd1);
      tick();
      check("to_fail_pmrst", {31'd0, pm_rst_n}, 32'd0);
      check("to_fail_cnt", {30'd0, fail_cnt}, {30'd0, exp_fail});
      tick();
   endtask

   initial begin
      // Reset state
      #3;
      check("rst_pm_rst_n", {31'd0, pm_rst_n}, 32'd0);
      check("rst_pwd_out", {31'd0, pwd_out}, 32'd0);
      check("rst_digit_cnt", {29'd0, digit_cnt}, 32'd0);
      check("rst_fail_cnt", {30'd0, fail_cnt}, 32'd0);
      tick();
      tick();
      check("rst_held_pm", {31'd0, pm_rst_n}, 32'd0);
      rst = 1'b1;
      tick();
      check("rst_release_pm", {31'd0, pm_rst_n}, 32'd1);

      // Test 1: user 2, keys 1 2 3 4, match two cycles after the strobe
      user_sel = 3'd2;
      press(4'd1);
      check("t1_dc1", {29'd0, digit_cnt}, 32'd1);
      check("t1_adrs", {29'd0, pass_adrs}, 32'd2);
      user_sel = 3'd5;
      press(4'd2);
      press(4'd3);
      check("t1_dc3", {29'd0, digit_cnt}, 32'd3);
      check("t1_pwd_out_early", {31'd0, pwd_out}, 32'd0);
      press(4'd4);
      check("t1_pwd_out", {31'd0, pwd_out}, 32'd1);
      check("t1_pwds", {16'd0, pwd1, pwd2, pwd3, pwd4}, 32'h1234);
      check("t1_adrs_kept", {29'd0, pass_adrs}, 32'd2);
      tick();
      check("t1_pwd_out_one", {31'd0, pwd_out}, 32'd0);
      check("t1_pwds_stable", {16'd0, pwd1, pwd2, pwd3, pwd4}, 32'h1234);
      pass_checked = 1'b1;
      tick();
      pass_checked = 1'b0;
      check("t1_logged_in", {31'd0, logged_in}, 32'd1);
      check("t1_fail_cnt", {30'd0, fail_cnt}, 32'd0);
      press(4'd7);
      check("t1_key_ignored", {16'd0, pwd1, pwd2, pwd3, pwd4}, 32'h1234);
      check("t1_still_in", {31'd0, logged_in}, 32'd1);

      // Test 2: logout
      logout = 1'b1;
      tick();
      logout = 1'b0;
      check("t2_pm_rst", {31'd0, pm_rst_n}, 32'd0);
      check("t2_logged_out", {31'd0, logged_in}, 32'd0);
      check("t2_pwds", {16'd0, pwd1, pwd2, pwd3, pwd4}, 32'h0000);
      check("t2_dc", {29'd0, digit_cnt}, 32'd0);
      tick();
      check("t2_pm_back", {31'd0, pm_rst_n}, 32'd1);
      logout = 1'b1;
      tick();
      logout = 1'b0;
      check("t2_logout_idle", {31'd0, pm_rst_n}, 32'd1);

      // Test 3: clear key, then a fresh entry
      press(4'hF);
      check("t3_f_idle", {29'd0, digit_cnt}, 32'd0);
      press(4'd5);
      check("t3_dc1", {29'd0, digit_cnt}, 32'd1);
      press(4'd6);
      check("t3_dc2", {29'd0, digit_cnt}, 32'd2);
      press(4'hF);
      check("t3_dc0", {29'd0, digit_cnt}, 32'd0);
      check("t3_pwds0", {16'd0, pwd1, pwd2, pwd3, pwd4}, 32'h0000);
      check("t3_no_strobe", {31'd0, pwd_out}, 32'd0);
      user_sel = 3'd6;
      enter4(4'd9, 4'd8, 4'd7, 4'd6);
      check("t3_new_strobe", {31'd0, pwd_out}, 32'd1);
      check("t3_new_pwds", {16'd0, pwd1, pwd2, pwd3, pwd4}, 32'h9876);
      check("t3_new_adrs", {29'd0, pass_adrs}, 32'd6);

      // Test 4: timeout, exactly 8 cycles after WAIT entry
      tick();
      for (int i = 0; i < 7; i++) tick();
      check("t4_not_yet", {31'd0, pm_rst_n}, 32'd1);
      check("t4_pwds_held", {16'd0, pwd1, pwd2, pwd3, pwd4}, 32'h9876);
      tick();
      check("t4_fail_pm", {31'd0, pm_rst_n}, 32'd0);
      check("t4_fail_cnt", {30'd0, fail_cnt}, 32'd1);
      check("t4_fail_pwds", {16'd0, pwd1, pwd2, pwd3, pwd4}, 32'h0000);
      tick();
      check("t4_pm_back", {31'd0, pm_rst_n}, 32'd1);
      check("t4_not_locked", {31'd0, locked}, 32'd0);
      pass_checked = 1'b1;
      tick();
      pass_checked = 1'b0;
      check("t4_pass_outside", {31'd0, logged_in}, 32'd0);

      // Pass coinciding with the last WAIT cycle wins over timeout
      enter4(4'd2, 4'd2, 4'd2, 4'd2);
      tick();
      for (int i = 0; i < 7; i++) tick();
      pass_checked = 1'b1;
      tick();
      pass_checked = 1'b0;
      check("tie_logged_in", {31'd0, logged_in}, 32'd1);
      check("tie_fail_cleared", {30'd0, fail_cnt}, 32'd0);
      check("tie_pm", {31'd0, pm_rst_n}, 32'd1);
      logout = 1'b1;
      tick();
      logout = 1'b0;
      tick();

      // Test 5: three timeouts -> 16-cycle lockout
      timeout_attempt(2'd1);
      timeout_attempt(2'd2);
      enter4(4'd1, 4'd1, 4'd1, 4'd1);
      tick();
      for (int i = 0; i < 8; i++) tick();
      check("t5_fail3", {30'd0, fail_cnt}, 32'd3);
      check("t5_not_locked_yet", {31'd0, locked}, 32'd0);
      tick();
      check("t5_locked", {31'd0, locked}, 32'd1);
      for (int i = 0; i < 15; i++) begin
         press(4'd3);
         check("t5_lock_hold", {31'd0, locked}, 32'd1);
         check("t5_lock_dc", {29'd0, digit_cnt}, 32'd0);
      end
      check("t5_fail_sat", {30'd0, fail_cnt}, 32'd3);
      tick();
      check("t5_unlocked", {31'd0, locked}, 32'd0);
      check("t5_fail_reset", {30'd0, fail_cnt}, 32'd0);
      press(4'd4);
      check("t5_accepts_keys", {29'd0, digit_cnt}, 32'd1);

      // Test 6: async reset mid-entry and during WAIT
      press(4'd5);
      check("t6_dc2", {29'd0, digit_cnt}, 32'd2);
      #1 rst = 1'b0;
      #1;
      check("t6_async_pm", {31'd0, pm_rst_n}, 32'd0);
      check("t6_async_dc", {29'd0, digit_cnt}, 32'd0);
      check("t6_async_pwds", {16'd0, pwd1, pwd2, pwd3, pwd4}, 32'h0000);
      check("t6_async_adrs", {29'd0, pass_adrs}, 32'd0);
      #1 rst = 1'b1;
      tick();
      check("t6_release_pm", {31'd0, pm_rst_n}, 32'd1);
      enter4(4'd8, 4'd8, 4'd8, 4'd8);
      tick();
      tick();
      #1 rst = 1'b0;
      #1;
      check("t6_wait_pm", {31'd0, pm_rst_n}, 32'd0);
      check("t6_wait_pwds", {16'd0, pwd1, pwd2, pwd3, pwd4}, 32'h0000);
      check("t6_wait_dc", {29'd0, digit_cnt}, 32'd0);
      #1 rst = 1'b1;
      tick();
      check("t6_wait_release", {31'd0, pm_rst_n}, 32'd1);
      enter4(4'd3, 4'd1, 4'd4, 4'd1);
      check("t6_fresh_strobe", {31'd0, pwd_out}, 32'd1);
      check("t6_fresh_pwds", {16'd0, pwd1, pwd2, pwd3, pwd4}, 32'h3141);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
